// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port, variable-latency memory between the core's
// instruction-fetch port (F stage) and its load/store port (M stage).
// One access is in flight at a time. Requests are held by the core until the
// matching Done pulse. The memory side is a req/ready handshake. All mem_*
// outputs are registered at grant time, so they stay stable until mem_ready.
//
// Parameters:
//   STARVE_LIMIT  consecutive data grants allowed while a fetch waits before
//                 the fetch is forced ahead of data (1..255)
//
// Ports:
//   clk, reset          clock (rising edge); asynchronous active-low reset
//   FetchReqF, PCF      fetch request / address (word-aligned on the bus)
//   InstrF, FetchDoneF  registered instruction, 1-cycle completion pulse
//   DataReqM, MemWriteM, ALUResultM, WriteDataM, BEDmem
//                       load/store request, direction, address, data, byte flag
//   ReadDataM, DataDoneM registered load data, 1-cycle completion pulse
//   StallF, StallM      pipeline stalls: request pending and not done
//   mem_req, mem_we, mem_addr, mem_wdata, mem_byte  memory request side
//   mem_rdata, mem_ready                            memory response side
//
// Optional feature (macro UNIFIED_MEM_ARB_PERF_EN):
//   perf_fetch_stall, perf_data_stall  saturating counts of StallF / StallM
//   cycles, cleared by reset. Without the macro these ports do not exist.
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FetchReqF,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        FetchDoneF,
  input  logic        DataReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        BEDmem,
  output logic [31:0] ReadDataM,
  output logic        DataDoneM,
  output logic        StallF,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_byte,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef UNIFIED_MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_fetch_stall,
  output logic [31:0] perf_data_stall
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT_C = STARVE_LIMIT[7:0];

  state_t      r_state;
  logic [7:0]  r_starve_cnt;
  logic [31:0] r_instr;
  logic [31:0] r_rdata;
  logic        r_fetch_done;
  logic        r_data_done;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_byte;

  logic w_fetch_pend;
  logic w_data_pend;
  logic w_data_win;

  // A request whose Done is pulsing this cycle has just been served; the
  // requester may still be holding it high, so it must not be granted again.
  assign w_fetch_pend = FetchReqF & ~r_fetch_done;
  assign w_data_pend  = DataReqM  & ~r_data_done;
  // Data has priority unless the waiting fetch has been passed over
  // STARVE_LIMIT times in a row.
  assign w_data_win   = w_data_pend & (~w_fetch_pend | (r_starve_cnt < LIMIT_C));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 8'd0;
      r_instr      <= 32'd0;
      r_rdata      <= 32'd0;
      r_fetch_done <= 1'b0;
      r_data_done  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_byte   <= 1'b0;
    end else begin
      r_fetch_done <= 1'b0;
      r_data_done  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (!FetchReqF) begin
            r_starve_cnt <= 8'd0;
          end
          if (w_data_win) begin
            r_state     <= ST_DATA;
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWriteM;
            r_mem_byte  <= BEDmem;
            r_mem_addr  <= ALUResultM;
            r_mem_wdata <= WriteDataM;
            if (w_fetch_pend && (r_starve_cnt != 8'hFF)) begin
              r_starve_cnt <= r_starve_cnt + 8'd1;
            end
          end else if (w_fetch_pend) begin
            r_state     <= ST_FETCH;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_byte  <= 1'b0;
            r_mem_addr  <= PCF & 32'hFFFF_FFFC;
            r_mem_wdata <= 32'd0;
          end
        end
        ST_FETCH: begin
          // Completes even if the fetch was flushed meanwhile; the core
          // simply ignores the Done pulse in that case.
          if (mem_ready) begin
            r_instr      <= mem_rdata;
            r_fetch_done <= 1'b1;
            r_starve_cnt <= 8'd0;
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_byte   <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
          end
        end
        ST_DATA: begin
          if (mem_ready) begin
            // Stores leave the last load value in place.
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
            r_data_done <= 1'b1;
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_byte  <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign InstrF     = r_instr;
  assign FetchDoneF = r_fetch_done;
  assign ReadDataM  = r_rdata;
  assign DataDoneM  = r_data_done;
  assign StallF     = FetchReqF & ~r_fetch_done;
  assign StallM     = DataReqM & ~r_data_done;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_byte   = r_mem_byte;

`ifdef UNIFIED_MEM_ARB_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetch <= 32'd0;
      r_perf_data  <= 32'd0;
    end else begin
      if (StallF && (r_perf_fetch != 32'hFFFF_FFFF)) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (StallM && (r_perf_data != 32'hFFFF_FFFF)) begin
        r_perf_data <= r_perf_data + 32'd1;
      end
    end
  end

  assign perf_fetch_stall = r_perf_fetch;
  assign perf_data_stall  = r_perf_data;
`endif

endmodule
